// File: rtl/act_pwl_pipe.sv
// act_pwl_pipe: three-stage pipelined tanh/sigmoid unit.
// Uses a shift-add piecewise-linear approximation; the function is chosen per sample.
// A valid/ready handshake provides backpressure; c_en freezes the whole pipe.
module act_pwl_pipe #(
  parameter int integer_dataWidth_i  = 5,
  parameter int fraction_dataWidth_i = 5,
  parameter int integer_dataWidth_o  = 4,
  parameter int fraction_dataWidth_o = 9
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                c_en,
  input  logic                                                mode,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [integer_dataWidth_i+fraction_dataWidth_i-1:0] data_in,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [integer_dataWidth_o+fraction_dataWidth_o-1:0] data_out,
  output logic                                                out_mode
);

  localparam int IW      = integer_dataWidth_i + fraction_dataWidth_i;
  localparam int OW      = integer_dataWidth_o + fraction_dataWidth_o;
  localparam int FI      = fraction_dataWidth_i;
  localparam int FO      = fraction_dataWidth_o;
  localparam int FW      = FI + 5;
  localparam int YW      = IW + 6;
  localparam int CW      = IW + 12;
  localparam int SH      = (FW > FO) ? (FW - FO) : 0;
  localparam int SL      = (FO > FW) ? (FO - FW) : 0;
  localparam int HALF_SH = (SH > 0) ? (SH - 1) : 0;
  localparam int RW      = YW + SL + 1;

  // Segment thresholds, expressed in sixteenths and aligned to the input fraction.
  localparam logic [CW-1:0] T_TANH_3 = CW'(40) << FI;
  localparam logic [CW-1:0] T_TANH_2 = CW'(19) << FI;
  localparam logic [CW-1:0] T_TANH_1 = CW'(8)  << FI;
  localparam logic [CW-1:0] T_SIGM_3 = CW'(80) << FI;
  localparam logic [CW-1:0] T_SIGM_2 = CW'(38) << FI;
  localparam logic [CW-1:0] T_SIGM_1 = CW'(16) << FI;

  // Intercepts, expressed in thirty-seconds and aligned to the internal fraction FW.
  localparam logic [YW-1:0] Y_ONE     = YW'(32) << FI;
  localparam logic [YW-1:0] I_TANH_2  = YW'(22) << FI;
  localparam logic [YW-1:0] I_TANH_1  = YW'(8)  << FI;
  localparam logic [YW-1:0] I_SIGM_2  = YW'(27) << FI;
  localparam logic [YW-1:0] I_SIGM_1  = YW'(20) << FI;
  localparam logic [YW-1:0] I_SIGM_0  = YW'(16) << FI;

  localparam logic [RW-1:0] HALF  = (SH > 0) ? (RW'(1) << HALF_SH) : '0;
  localparam logic [OW-1:0] ONE_O = OW'(1) << FO;

  logic          adv;
  logic          accept;
  logic [IW-1:0] abs_in;
  logic [CW-1:0] a_cmp;
  logic [1:0]    seg_in;

  logic          v1;
  logic          sign1;
  logic          mode1;
  logic [IW-1:0] a1;
  logic [1:0]    seg1;

  logic [YW-1:0] a_y;
  logic [YW-1:0] y_next;

  logic          v2;
  logic          sign2;
  logic          mode2;
  logic [YW-1:0] y2;

  logic [RW-1:0] y_round;
  logic [OW-1:0] mag;
  logic [OW-1:0] out_next;

  assign adv      = c_en & ~reset & (~out_valid | out_ready);
  assign in_ready = adv;
  assign accept   = in_valid & adv;

  assign abs_in = data_in[IW-1] ? (~data_in + IW'(1)) : data_in;
  assign a_cmp  = CW'({abs_in, 4'b0000});

  // Stage 1 segment selection: pick the linear piece from the magnitude and mode.
  always_comb begin
    seg_in = 2'd0;
    if (!mode) begin
      if (a_cmp >= T_TANH_3)      seg_in = 2'd3;
      else if (a_cmp >= T_TANH_2) seg_in = 2'd2;
      else if (a_cmp >= T_TANH_1) seg_in = 2'd1;
    end else begin
      if (a_cmp >= T_SIGM_3)      seg_in = 2'd3;
      else if (a_cmp >= T_SIGM_2) seg_in = 2'd2;
      else if (a_cmp >= T_SIGM_1) seg_in = 2'd1;
    end
  end

  assign a_y = YW'(a1);

  // Stage 2 magnitude: slope is a power of two, so each piece is one shift plus one add.
  always_comb begin
    y_next = '0;
    unique case ({mode1, seg1})
      3'b0_11: y_next = Y_ONE;
      3'b0_10: y_next = (a_y << 2) + I_TANH_2;
      3'b0_01: y_next = (a_y << 4) + I_TANH_1;
      3'b0_00: y_next = a_y << 5;
      3'b1_11: y_next = Y_ONE;
      3'b1_10: y_next = a_y + I_SIGM_2;
      3'b1_01: y_next = (a_y << 2) + I_SIGM_1;
      3'b1_00: y_next = (a_y << 3) + I_SIGM_0;
      default: y_next = '0;
    endcase
  end

  // Stage 3 output: round the magnitude half-up first, then apply negation or complement.
  always_comb begin
    y_round  = ((RW'(y2) + HALF) >> SH) << SL;
    mag      = OW'(y_round);
    out_next = mag;
    if (sign2) begin
      if (mode2) out_next = ONE_O - mag;
      else       out_next = ~mag + OW'(1);
    end
  end

  // Pipeline registers: all three stages advance together, or all hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      sign1     <= 1'b0;
      mode1     <= 1'b0;
      a1        <= '0;
      seg1      <= 2'd0;
      v2        <= 1'b0;
      sign2     <= 1'b0;
      mode2     <= 1'b0;
      y2        <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      out_mode  <= 1'b0;
    end else if (adv) begin
      v1        <= accept;
      sign1     <= data_in[IW-1];
      mode1     <= mode;
      a1        <= abs_in;
      seg1      <= seg_in;
      v2        <= v1;
      sign2     <= sign1;
      mode2     <= mode1;
      y2        <= y_next;
      out_valid <= v2;
      data_out  <= out_next;
      out_mode  <= mode2;
    end
  end

endmodule

// File: tb/tb_act_pwl_pipe.sv
// tb_act_pwl_pipe: scoreboard bench for act_pwl_pipe with default parameters.
module tb_act_pwl_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_en;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  data_in;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] data_out;
  logic        out_mode;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [13:0] sb_q[$];
  logic [13:0] sb_exp;

  logic [9:0]  dir_x   [8] = '{10'b0000001000, 10'b1111100000, 10'b0001001000, 10'b0000000000,
                               10'b0000110000, 10'b1000000000, 10'b0001001101, 10'b1110110011};
  logic        dir_m   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [12:0] dir_exp [8] = '{13'd128, 13'h1E80, 13'd496, 13'd256,
                               13'd416, 13'd0, 13'd471, 13'd41};

  act_pwl_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .c_en      (c_en),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_mode  (out_mode)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference model in units of 1/1024 with half-up rounding to 1/512.
  function automatic logic [12:0] model(input logic m, input logic [9:0] x);
    int xs, a, y, yr, r;
    xs = int'($signed(x));
    a  = (xs < 0) ? -xs : xs;
    if (!m) begin
      if (a >= 80)      y = 1024;
      else if (a >= 38) y = a * 4 + 704;
      else if (a >= 16) y = a * 16 + 256;
      else              y = a * 32;
    end else begin
      if (a >= 160)     y = 1024;
      else if (a >= 76) y = a + 864;
      else if (a >= 32) y = a * 4 + 640;
      else              y = a * 8 + 512;
    end
    yr = (y + 1) / 2;
    if (xs >= 0)  r = yr;
    else if (!m)  r = -yr;
    else          r = 512 - yr;
    model = r[12:0];
  endfunction

  // Scoreboard: push on accept, pop and compare on every consumed result.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready && c_en) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_unexpected got mode=%b data=%h, no result expected", out_mode, data_out);
        end else begin
          sb_exp = sb_q.pop_front();
          pops++;
          if ({out_mode, data_out} !== sb_exp) begin
            errors++;
            $display("[TB] FAIL sb_result got mode=%b data=%h expected mode=%b data=%h",
                     out_mode, data_out, sb_exp[13], sb_exp[12:0]);
          end
        end
      end
      if (in_valid && in_ready) sb_q.push_back({mode, model(mode, data_in)});
    end
  end

  // Global time limit.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send(input logic m, input logic [9:0] x);
    int n;
    n        = 0;
    in_valid = 1'b1;
    mode     = m;
    data_in  = x;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout pending=%0d required 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    c_en      = 1'b1;
    in_valid  = 1'b0;
    mode      = 1'b0;
    data_in   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_ready got %b required 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid got %b required 0", out_valid);
    end
    checks++;
    if (data_out !== 13'd0) begin
      errors++;
      $display("[TB] FAIL reset_data_out got %h required 0", data_out);
    end
    checks++;
    if (out_mode !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_mode got %b required 0", out_mode);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(dir_m[i], dir_x[i]);
      n = 1;
      while (!out_valid && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      checks++;
      if (n != 3) begin
        errors++;
        $display("[TB] FAIL directed_latency[%0d] got %0d cycles required 3", i, n);
      end
      checks++;
      if (data_out !== dir_exp[i] || out_mode !== dir_m[i]) begin
        errors++;
        $display("[TB] FAIL directed_value[%0d] got data=%h mode=%b required data=%h mode=%b",
                 i, data_out, out_mode, dir_exp[i], dir_m[i]);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int n, run;
    n         = 0;
    run       = 0;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send(i[0], 10'($urandom_range(0, 1023)));
      end
      begin
        while (!out_valid && n < 40) begin
          @(negedge clk);
          n++;
        end
        while (out_valid && run < 20) begin
          run++;
          @(negedge clk);
        end
      end
    join
    checks++;
    if (run != 8) begin
      errors++;
      $display("[TB] FAIL b2b_run got %0d consecutive valid cycles required 8", run);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int          p0;
    logic [9:0]  x0;
    logic [12:0] e0;
    p0        = pops;
    x0        = 10'($urandom_range(0, 1023));
    e0        = model(1'b0, x0);
    out_ready = 1'b0;
    send(1'b0, x0);
    send(1'b1, 10'($urandom_range(0, 1023)));
    send(1'b0, 10'($urandom_range(0, 1023)));
    in_valid = 1'b1;
    mode     = 1'b1;
    data_in  = 10'($urandom_range(0, 1023));
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_in_ready got %b required 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || data_out !== e0) begin
        errors++;
        $display("[TB] FAIL bp_hold got valid=%b data=%h required valid=1 data=%h", out_valid, data_out, e0);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(1'b1, data_in);
    drain();
    checks++;
    if (pops - p0 != 4) begin
      errors++;
      $display("[TB] FAIL bp_count got %0d results required 4", pops - p0);
    end
  endtask

  task automatic test_cen_freeze();
    int          p0;
    logic [9:0]  x0;
    logic [12:0] e0;
    p0        = pops;
    x0        = 10'($urandom_range(0, 1023));
    e0        = model(1'b1, x0);
    out_ready = 1'b1;
    send(1'b1, x0);
    send(1'b0, 10'($urandom_range(0, 1023)));
    send(1'b1, 10'($urandom_range(0, 1023)));
    c_en     = 1'b0;
    in_valid = 1'b1;
    mode     = 1'b0;
    data_in  = 10'($urandom_range(0, 1023));
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL cen_in_ready got %b required 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || data_out !== e0 || out_mode !== 1'b1) begin
        errors++;
        $display("[TB] FAIL cen_hold got valid=%b data=%h mode=%b required valid=1 data=%h mode=1",
                 out_valid, data_out, out_mode, e0);
      end
    end
    @(posedge clk);
    #1;
    c_en = 1'b1;
    send(1'b0, data_in);
    send(1'b1, 10'($urandom_range(0, 1023)));
    send(1'b0, 10'($urandom_range(0, 1023)));
    drain();
    checks++;
    if (pops - p0 != 6) begin
      errors++;
      $display("[TB] FAIL cen_count got %0d results required 6", pops - p0);
    end
  endtask

  task automatic test_reset_midflight();
    int stale;
    stale     = 0;
    out_ready = 1'b1;
    send(1'b0, 10'($urandom_range(0, 1023)));
    send(1'b1, 10'($urandom_range(0, 1023)));
    send(1'b0, 10'($urandom_range(0, 1023)));
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_in_ready got %b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || data_out !== 13'd0) begin
      errors++;
      $display("[TB] FAIL midrst_clear got valid=%b data=%h required valid=0 data=0", out_valid, data_out);
    end
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("[TB] FAIL midrst_stale got %0d valid cycles required 0", stale);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweep();
    out_ready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 1024; x++) send(m[0], 10'(x));
    end
    drain();
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_cen_freeze();
    test_reset_midflight();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
